// File: rtl/alu_pipe.sv
// alu_pipe -- registered ALU with valid/ready handshakes on both sides.
//
// One op is accepted per in_valid & in_ready transfer. Non-multiply ops load
// the output registers on the accepting edge, so the result is presented on
// the following cycle. An internal carry/shift flag (sc_q) persists across
// ops and feeds ADC.
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined   -> MUL is an iterative shift-add multiplier (one bit per cycle,
//                IDLE/BUSY FSM, WIDTH+1 cycles from accept to out_valid).
//   undefined -> MUL is treated like the reserved opcode. No FSM is built.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   in_valid / in_ready   input handshake (transfer = in_valid & in_ready)
//   alu_cmd, inA, inB     opcode and operands, sampled only on transfer
//   out_valid / out_ready output handshake (transfer = out_valid & out_ready)
//   rslt                  registered result
//   sc_o                  carry / borrow / shift-out (or overflow for MUL)
//   pari, zero, one       ^rslt, rslt==0, rslt==1
//   bad_op                op was reserved or disabled
//   sc_q                  current internal carry register
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero,
  output logic             one,
  output logic             bad_op,
  output logic             sc_q
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADC   = 4'b0010;
  localparam logic [3:0] OP_PASSA = 4'b0011;
  localparam logic [3:0] OP_PASSB = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_EQ    = 4'b1100;
  localparam logic [3:0] OP_LT    = 4'b1101;
  localparam logic [3:0] OP_RXOR  = 4'b1110;
  localparam logic [3:0] OP_RSV   = 4'b1111;

  // Registered outputs
  logic             out_valid_reg;
  logic [WIDTH-1:0] rslt_reg;
  logic             sc_o_reg;
  logic             pari_reg;
  logic             zero_reg;
  logic             one_reg;
  logic             bad_reg;
  logic             sc_reg;

  logic accept;
  assign accept = in_valid & in_ready;

  // ------------------------------------------------------------------
  // Single-cycle datapath
  // ------------------------------------------------------------------
  logic [SHW-1:0]   sh_amt;
  logic             sh_hi;
  logic             sh_big;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH:0]   adc_w;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_sc;
  logic             alu_bad;
  logic             alu_upd_sc;

  assign sh_amt = inB[SHW-1:0];
  assign sh_hi  = |inB[WIDTH-1:SHW];

  // Any nonzero bit above the shift field means "shift by WIDTH or more".
  // For non-power-of-two widths the field itself can also exceed WIDTH-1.
  generate
    if ((1 << SHW) == WIDTH) begin : g_sh_pow2
      assign sh_big = sh_hi;
    end else begin : g_sh_npow2
      localparam logic [SHW-1:0] SH_LIM = SHW'(WIDTH);
      assign sh_big = sh_hi | (sh_amt >= SH_LIM);
    end
  endgenerate

  always_comb begin
    sum_w = {1'b0, inA} + {1'b0, inB};
    dif_w = {1'b0, inA} - {1'b0, inB};
    adc_w = sum_w + {{WIDTH{1'b0}}, sc_reg};
    // One guard bit beyond the result catches the last bit shifted out;
    // a zero shift leaves the guard bit clear, giving sc_o=0.
    sll_w = {1'b0, inA} << sh_amt;
    srl_w = {inA, 1'b0} >> sh_amt;

    alu_res    = '0;
    alu_sc     = 1'b0;
    alu_bad    = 1'b0;
    alu_upd_sc = 1'b0;
    case (alu_cmd)
      OP_ADD:   begin alu_res = sum_w[WIDTH-1:0]; alu_sc = sum_w[WIDTH]; alu_upd_sc = 1'b1; end
      OP_SUB:   begin alu_res = dif_w[WIDTH-1:0]; alu_sc = dif_w[WIDTH]; alu_upd_sc = 1'b1; end
      OP_ADC:   begin alu_res = adc_w[WIDTH-1:0]; alu_sc = adc_w[WIDTH]; alu_upd_sc = 1'b1; end
      OP_PASSA: alu_res = inA;
      OP_PASSB: alu_res = inB;
      OP_NOR:   alu_res = ~(inA | inB);
      OP_XOR:   alu_res = inA ^ inB;
      OP_AND:   alu_res = inA & inB;
      OP_OR:    alu_res = inA | inB;
      OP_SLL: begin
        alu_upd_sc = 1'b1;
        if (!sh_big) begin
          alu_res = sll_w[WIDTH-1:0];
          alu_sc  = sll_w[WIDTH];
        end
      end
      OP_SRL: begin
        alu_upd_sc = 1'b1;
        if (!sh_big) begin
          alu_res = srl_w[WIDTH:1];
          alu_sc  = srl_w[0];
        end
      end
      OP_EQ:    alu_res[0] = (inA == inB);
      OP_LT:    alu_res[0] = (inA < inB);
      OP_RXOR:  alu_res[0] = ^inB;
      // MUL lands here too; with the multiplier enabled it never loads
      // through this path.
      OP_MUL, OP_RSV: alu_bad = 1'b1;
      default:  alu_bad = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------
  // Output-register load source
  // ------------------------------------------------------------------
  logic             ld_en;
  logic [WIDTH-1:0] ld_res;
  logic             ld_sc;
  logic             ld_bad;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t             state_reg;
  logic [2*WIDTH-1:0] mul_acc_reg;
  logic [2*WIDTH-1:0] mul_a_reg;
  logic [WIDTH-1:0]   mul_b_reg;
  logic [SHW-1:0]     mul_cnt_reg;
  logic [2*WIDTH-1:0] mul_sum;
  logic               is_mul;
  logic               mul_done;

  assign is_mul   = (alu_cmd == OP_MUL);
  assign mul_sum  = mul_acc_reg + (mul_b_reg[0] ? mul_a_reg : '0);
  // The final partial product is added on the same edge that loads the
  // outputs, so BUSY lasts exactly WIDTH cycles.
  assign mul_done = (state_reg == BUSY) && (mul_cnt_reg == CNT_LAST);
  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);

  always_comb begin
    if (mul_done) begin
      ld_en  = 1'b1;
      ld_res = mul_sum[WIDTH-1:0];
      ld_sc  = |mul_sum[2*WIDTH-1:WIDTH];
      ld_bad = 1'b0;
    end else begin
      ld_en  = accept && !is_mul;
      ld_res = alu_res;
      ld_sc  = alu_sc;
      ld_bad = alu_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      mul_acc_reg <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      mul_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && is_mul) begin
            state_reg   <= BUSY;
            mul_acc_reg <= '0;
            mul_a_reg   <= {{WIDTH{1'b0}}, inA};
            mul_b_reg   <= inB;
            mul_cnt_reg <= '0;
          end
        end
        BUSY: begin
          mul_acc_reg <= mul_sum;
          mul_a_reg   <= mul_a_reg << 1;
          mul_b_reg   <= mul_b_reg >> 1;
          mul_cnt_reg <= mul_cnt_reg + 1'b1;
          if (mul_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = !out_valid_reg || out_ready;

  always_comb begin
    ld_en  = accept;
    ld_res = alu_res;
    ld_sc  = alu_sc;
    ld_bad = alu_bad;
  end
`endif

  // ------------------------------------------------------------------
  // Output and carry registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      rslt_reg      <= '0;
      sc_o_reg      <= 1'b0;
      pari_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      one_reg       <= 1'b0;
      bad_reg       <= 1'b0;
      sc_reg        <= 1'b0;
    end else begin
      if (ld_en) begin
        out_valid_reg <= 1'b1;
        rslt_reg      <= ld_res;
        sc_o_reg      <= ld_sc;
        bad_reg       <= ld_bad;
        pari_reg      <= ^ld_res;
        zero_reg      <= (ld_res == '0);
        one_reg       <= (ld_res == WIDTH'(1));
      end else if (accept || out_ready) begin
        // Any accept implies the old result was consumed (a MUL accept
        // starts BUSY with nothing to present).
        out_valid_reg <= 1'b0;
      end
      if (accept && alu_upd_sc) sc_reg <= alu_sc;
    end
  end

  assign out_valid = out_valid_reg;
  assign rslt      = rslt_reg;
  assign sc_o      = sc_o_reg;
  assign pari      = pari_reg;
  assign zero      = zero_reg;
  assign one       = one_reg;
  assign bad_op    = bad_reg;
  assign sc_q      = sc_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8). Stimulus pushes the hand-computed
// expected response when an op is accepted; a separate monitor pops and
// compares whenever a result is transferred.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt;
  logic         sc_o, pari, zero, one, bad_op, sc_q;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB),
    .out_valid(out_valid), .out_ready(out_ready),
    .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero), .one(one),
    .bad_op(bad_op), .sc_q(sc_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   cmd;
    logic [W-1:0] r;
    logic         sc;
    logic         bad;
    logic         scq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for acceptance, push the expectation.
  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic esc, input logic ebad,
                       input logic escq, input bit push_it);
    int waited;
    exp_t e;
    waited   = 0;
    alu_cmd  = cmd;
    inA      = a;
    inB      = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: cmd %0h never accepted in_ready=%0b", cmd, in_ready);
      step();
      in_valid = 1'b0;
    end else begin
      e.cmd = cmd; e.r = er; e.sc = esc; e.bad = ebad; e.scq = escq;
      if (push_it) exp_q.push_back(e);
      step();
      in_valid = 1'b0;
      // Operands need not be held after accept.
      inA = ~a;
      inB = ~b;
    end
  endtask

  // Monitor: compare on every output transfer.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: rslt %0h with empty scoreboard", rslt);
      end else begin
        exp_t e;
        logic [11:0] got, want;
        e    = exp_q.pop_front();
        got  = {rslt, sc_o, bad_op, sc_q, pari};
        want = {e.r, e.sc, e.bad, e.scq, ^e.r};
        txn++;
        $display("txn %0d cmd=%0h rslt=%0h sc_o=%0b bad_op=%0b sc_q=%0b pari=%0b zero=%0b one=%0b",
                 txn, e.cmd, rslt, sc_o, bad_op, sc_q, pari, zero, one);
        chk($sformatf("txn%0d_cmd%0h", txn, e.cmd), {20'd0, got}, {20'd0, want});
        chk($sformatf("txn%0d_zero_one", txn), {30'd0, zero, one},
            {30'd0, (e.r == 8'd0), (e.r == 8'd1)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_cmd   = 4'h0;
    inA       = '0;
    inB       = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", {24'd0, out_valid, rslt == 8'd0, sc_o, pari, zero, one, bad_op, sc_q},
        {24'd0, 1'b0, 1'b1, 6'b000000});
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Put sc_q at 1, then reset in the middle of a MUL with the output held.
    issue(4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    step(); step();
    out_ready = 1'b0;
    issue(4'h5, 8'd16, 8'd17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", {29'd0, out_valid, sc_q, in_ready}, {29'd0, 3'b001});
    step();
    out_ready = 1'b1;

    // Directed vectors: cmd, a, b, rslt, sc_o, bad_op, sc_q-after
    issue(4'h0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b1, 1'b1);  // ADD carry
    issue(4'h2, 8'd1,   8'd1,   8'd3,   1'b0, 1'b0, 1'b0, 1'b1);  // ADC uses sc_q
    issue(4'h1, 8'd5,   8'd6,   8'd255, 1'b1, 1'b0, 1'b1, 1'b1);  // SUB borrow
    issue(4'hA, 8'h81,  8'd1,   8'h02,  1'b1, 1'b0, 1'b1, 1'b1);  // SLL 1
    issue(4'hB, 8'h81,  8'd8,   8'h00,  1'b0, 1'b0, 1'b0, 1'b1);  // SRL >= W
    issue(4'hE, 8'h55,  8'h07,  8'h01,  1'b0, 1'b0, 1'b0, 1'b1);  // RXOR
    issue(4'h0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0, 1'b1, 1'b1);  // ADD wrap
    issue(4'hF, 8'h12,  8'h34,  8'h00,  1'b0, 1'b1, 1'b1, 1'b1);  // reserved
    issue(4'h6, 8'hF0,  8'h0C,  8'h03,  1'b0, 1'b0, 1'b1, 1'b1);  // NOR
    issue(4'h7, 8'hF0,  8'h3C,  8'hCC,  1'b0, 1'b0, 1'b1, 1'b1);  // XOR
    issue(4'h8, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b1, 1'b1);  // AND
    issue(4'h9, 8'hF0,  8'h3C,  8'hFC,  1'b0, 1'b0, 1'b1, 1'b1);  // OR
    issue(4'hC, 8'd7,   8'd7,   8'h01,  1'b0, 1'b0, 1'b1, 1'b1);  // EQ true
    issue(4'hC, 8'd7,   8'd6,   8'h00,  1'b0, 1'b0, 1'b1, 1'b1);  // EQ false
    issue(4'hD, 8'd3,   8'd9,   8'h01,  1'b0, 1'b0, 1'b1, 1'b1);  // LT true
    issue(4'hD, 8'd9,   8'd3,   8'h00,  1'b0, 1'b0, 1'b1, 1'b1);  // LT false
    issue(4'h3, 8'hA5,  8'h00,  8'hA5,  1'b0, 1'b0, 1'b1, 1'b1);  // PASSA
    issue(4'h4, 8'h11,  8'h80,  8'h80,  1'b0, 1'b0, 1'b1, 1'b1);  // PASSB
    issue(4'hB, 8'h81,  8'd1,   8'h40,  1'b1, 1'b0, 1'b1, 1'b1);  // SRL 1
    issue(4'hA, 8'h81,  8'd0,   8'h81,  1'b0, 1'b0, 1'b0, 1'b1);  // SLL 0
    issue(4'h2, 8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b1);  // ADC sc_q=0
    issue(4'hA, 8'h81,  8'h10,  8'h00,  1'b0, 1'b0, 1'b0, 1'b1);  // SLL hi bits
    issue(4'hA, 8'h03,  8'd7,   8'h80,  1'b1, 1'b0, 1'b1, 1'b1);  // SLL 7
    issue(4'hB, 8'hC0,  8'd7,   8'h01,  1'b1, 1'b0, 1'b1, 1'b1);  // SRL 7
    @(negedge clk);
    chk("latency_one", {31'd0, out_valid}, 32'd1);
    step(); step();

    // MUL: latency and result depend on the build option.
    if (MUL_EN) issue(4'h5, 8'd16, 8'd17, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1);
    else        issue(4'h5, 8'd16, 8'd17, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 30);
    chk("mul_latency", cnt, MUL_EN ? 32'd9 : 32'd1);
    step(); step();

    // Backpressure: three ops against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        issue(4'h0, 8'd10,  8'd20,  8'd30,  1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'h7, 8'h0F,  8'hFF,  8'hF0,  1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'h1, 8'd50,  8'd8,   8'd42,  1'b0, 1'b0, 1'b0, 1'b1);
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!out_valid && cnt < 20);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("bp_hold%0d", i), {22'd0, out_valid, in_ready, rslt},
              {22'd0, 1'b1, 1'b0, 8'd30});
          if (i < 3) @(negedge clk);
        end
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk($sformatf("bp_stream%0d", i), {31'd0, out_valid}, 32'd1);
        end
      end
    join
    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
